// File: rtl/shot_sequencer.sv
// shot_sequencer: run controller for the optical sync-pulse chain.
// Arms on a start edge, fires the chain a locked number of times at a minimum spacing, and flags a stalled chain.
module shot_sequencer #(
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned REP_W   = 8,
  parameter int unsigned ARM_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_start,
  input  logic             pc_start,
  input  logic             abort,
  input  logic             cfg_valid,
  input  logic [REP_W-1:0] cfg_repeat,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_timeout,
  input  logic             end_flg,
  output logic             fire,
  output logic             busy,
  output logic             cfg_lock,
  output logic             done,
  output logic             start_rej,
  output logic             err_timeout,
  output logic [REP_W-1:0] shot_cnt
);

  localparam int unsigned ARM_W = (ARM_CYC > 1) ? $clog2(ARM_CYC) : 1;
  localparam logic [ARM_W-1:0] ARM_LOAD = ARM_W'(ARM_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARM      = 3'd1,
    S_FIRE     = 3'd2,
    S_WAIT_END = 3'd3,
    S_GAP      = 3'd4,
    S_ERR      = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic btn_prev_q, btn_prev_d;
  logic pc_prev_q, pc_prev_d;
  logic end_prev_q, end_prev_d;

  logic             fire_q, fire_d;
  logic             busy_q, busy_d;
  logic             cfg_lock_q, cfg_lock_d;
  logic             done_q, done_d;
  logic             start_rej_q, start_rej_d;
  logic             err_timeout_q, err_timeout_d;
  logic [REP_W-1:0] shot_cnt_q, shot_cnt_d;

  logic [REP_W-1:0] sh_repeat_q, sh_repeat_d;
  logic [CNT_W-1:0] sh_period_q, sh_period_d;
  logic [CNT_W-1:0] sh_timeout_q, sh_timeout_d;
  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  logic             start_req;
  logic             end_edge;
  logic             cfg_ok;
  logic             gap_ok;
  logic             tmo_hit;
  logic             last_shot;
  logic [CNT_W-1:0] per_load;

  // Request/end edge detection and run-decision terms.
  always_comb begin
    start_req = (btn_start & ~btn_prev_q) | (pc_start & ~pc_prev_q);
    end_edge  = end_flg & ~end_prev_q;
    cfg_ok    = cfg_valid && (cfg_repeat != '0);
    gap_ok    = (per_cnt_q == '0);
    tmo_hit   = (sh_timeout_q != '0) && (tmo_cnt_q == CNT_W'(1));
    last_shot = (shot_cnt_q == sh_repeat_q);
  end

  // Period counter is loaded two short of the period: the FIRE state precedes
  // the registered fire pulse by one cycle, and spacing never drops below 2.
  always_comb begin
    per_load = '0;
    if (sh_period_q >= CNT_W'(2)) begin
      per_load = sh_period_q - CNT_W'(2);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides everything.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_req && cfg_ok) begin
            state_d = S_ARM;
          end
        end
        S_ARM: begin
          if (arm_cnt_q == '0) begin
            state_d = S_FIRE;
          end
        end
        S_FIRE: begin
          state_d = S_WAIT_END;
        end
        S_WAIT_END: begin
          if (end_edge) begin
            if (last_shot) begin
              state_d = S_IDLE;
            end else if (gap_ok) begin
              state_d = S_FIRE;
            end else begin
              state_d = S_GAP;
            end
          end else if (tmo_hit) begin
            state_d = S_ERR;
          end
        end
        S_GAP: begin
          if (gap_ok) begin
            state_d = S_FIRE;
          end
        end
        S_ERR: begin
          state_d = S_ERR;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Output and datapath next values.
  always_comb begin
    btn_prev_d    = btn_start;
    pc_prev_d     = pc_start;
    end_prev_d    = end_flg;
    fire_d        = 1'b0;
    done_d        = 1'b0;
    start_rej_d   = 1'b0;
    busy_d        = busy_q;
    cfg_lock_d    = cfg_lock_q;
    err_timeout_d = err_timeout_q;
    shot_cnt_d    = shot_cnt_q;
    sh_repeat_d   = sh_repeat_q;
    sh_period_d   = sh_period_q;
    sh_timeout_d  = sh_timeout_q;
    arm_cnt_d     = arm_cnt_q;
    per_cnt_d     = (per_cnt_q != '0) ? (per_cnt_q - CNT_W'(1)) : '0;
    tmo_cnt_d     = (tmo_cnt_q != '0) ? (tmo_cnt_q - CNT_W'(1)) : '0;

    if (abort) begin
      busy_d        = 1'b0;
      cfg_lock_d    = 1'b0;
      err_timeout_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_req) begin
            if (cfg_ok) begin
              sh_repeat_d  = cfg_repeat;
              sh_period_d  = cfg_period;
              sh_timeout_d = cfg_timeout;
              shot_cnt_d   = '0;
              busy_d       = 1'b1;
              cfg_lock_d   = 1'b1;
              arm_cnt_d    = ARM_LOAD;
            end else begin
              start_rej_d = 1'b1;
            end
          end
        end
        S_ARM: begin
          if (arm_cnt_q != '0) begin
            arm_cnt_d = arm_cnt_q - ARM_W'(1);
          end
        end
        S_FIRE: begin
          fire_d     = 1'b1;
          shot_cnt_d = shot_cnt_q + REP_W'(1);
          per_cnt_d  = per_load;
          tmo_cnt_d  = sh_timeout_q;
        end
        S_WAIT_END: begin
          if (end_edge) begin
            if (last_shot) begin
              done_d     = 1'b1;
              busy_d     = 1'b0;
              cfg_lock_d = 1'b0;
            end
          end else if (tmo_hit) begin
            err_timeout_d = 1'b1;
            busy_d        = 1'b0;
            cfg_lock_d    = 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output and datapath registers; previous samples reset high to mask levels present at reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev_q    <= 1'b1;
      pc_prev_q     <= 1'b1;
      end_prev_q    <= 1'b1;
      fire_q        <= 1'b0;
      busy_q        <= 1'b0;
      cfg_lock_q    <= 1'b0;
      done_q        <= 1'b0;
      start_rej_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      shot_cnt_q    <= '0;
      sh_repeat_q   <= '0;
      sh_period_q   <= '0;
      sh_timeout_q  <= '0;
      arm_cnt_q     <= '0;
      per_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
    end else begin
      btn_prev_q    <= btn_prev_d;
      pc_prev_q     <= pc_prev_d;
      end_prev_q    <= end_prev_d;
      fire_q        <= fire_d;
      busy_q        <= busy_d;
      cfg_lock_q    <= cfg_lock_d;
      done_q        <= done_d;
      start_rej_q   <= start_rej_d;
      err_timeout_q <= err_timeout_d;
      shot_cnt_q    <= shot_cnt_d;
      sh_repeat_q   <= sh_repeat_d;
      sh_period_q   <= sh_period_d;
      sh_timeout_q  <= sh_timeout_d;
      arm_cnt_q     <= arm_cnt_d;
      per_cnt_q     <= per_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  assign fire        = fire_q;
  assign busy        = busy_q;
  assign cfg_lock    = cfg_lock_q;
  assign done        = done_q;
  assign start_rej   = start_rej_q;
  assign err_timeout = err_timeout_q;
  assign shot_cnt    = shot_cnt_q;

endmodule

// File: tb/tb_shot_sequencer.sv
// tb_shot_sequencer: edge-timeline reference model checked every cycle, directed scenarios with
// literal timing expectations, then randomized starts/aborts/config churn.
module tb_shot_sequencer;

  localparam int unsigned CNT_W   = 24;
  localparam int unsigned REP_W   = 8;
  localparam int unsigned ARM_CYC = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             btn_start = 1'b1;
  logic             pc_start = 1'b0;
  logic             abort = 1'b0;
  logic             cfg_valid = 1'b1;
  logic [REP_W-1:0] cfg_repeat = 8'd3;
  logic [CNT_W-1:0] cfg_period = 24'd100;
  logic [CNT_W-1:0] cfg_timeout = 24'd0;
  logic             end_flg = 1'b0;
  logic             fire, busy, cfg_lock, done, start_rej, err_timeout;
  logic [REP_W-1:0] shot_cnt;

  always #5 clk = ~clk;

  shot_sequencer #(.CNT_W(CNT_W), .REP_W(REP_W), .ARM_CYC(ARM_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .pc_start(pc_start), .abort(abort),
    .cfg_valid(cfg_valid), .cfg_repeat(cfg_repeat), .cfg_period(cfg_period),
    .cfg_timeout(cfg_timeout), .end_flg(end_flg), .fire(fire), .busy(busy),
    .cfg_lock(cfg_lock), .done(done), .start_rej(start_rej), .err_timeout(err_timeout),
    .shot_cnt(shot_cnt)
  );

  int     n_pass = 0;
  int     n_total = 0;
  longint cyc = 0;

  // Reference model: run described as a timeline of edge numbers.
  int     m_mode = 0;  // 0 idle, 1 running, 2 error hold
  bit     m_wait = 1'b0;
  longint m_next = 0, m_f = 0, m_per = 0, m_tmo = 0;
  int     m_rep = 0, m_shots = 0;
  bit     mp_btn = 1'b1, mp_pc = 1'b1, mp_end = 1'b1;
  bit     e_fire = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_rej = 1'b0, e_err = 1'b0;
  int     e_shot = 0;

  // End-flag responder controls and event logs.
  int     end_dly = 20;
  bit     rnd_end = 1'b0;
  longint end_at = -10;
  longint fire_log[$], done_log[$], rej_log[$], err_log[$];
  bit     err_prev = 1'b0;

  initial forever begin
    bit     st, ee;
    longint peff;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_mode = 0; m_wait = 0; m_shots = 0;
      mp_btn = 1; mp_pc = 1; mp_end = 1;
      e_fire = 0; e_busy = 0; e_done = 0; e_rej = 0; e_err = 0;
    end else begin
      st = (btn_start && !mp_btn) || (pc_start && !mp_pc);
      ee = end_flg && !mp_end;
      mp_btn = btn_start; mp_pc = pc_start; mp_end = end_flg;
      e_fire = 0; e_done = 0; e_rej = 0;
      if (abort) begin
        m_mode = 0; e_busy = 0; e_err = 0;
      end else if (m_mode == 0) begin
        if (st) begin
          if (!cfg_valid || cfg_repeat == 0) begin
            e_rej = 1;
          end else begin
            m_rep = int'(cfg_repeat); m_per = longint'(cfg_period); m_tmo = longint'(cfg_timeout);
            m_shots = 0; e_busy = 1; m_next = cyc + ARM_CYC + 1; m_wait = 0; m_mode = 1;
          end
        end
      end else if (m_mode == 1) begin
        if (m_wait) begin
          if (ee) begin
            if (m_shots == m_rep) begin
              e_done = 1; e_busy = 0; m_mode = 0;
            end else begin
              peff = (m_per < 2) ? 2 : m_per;
              m_next = (m_f + peff > cyc + 1) ? (m_f + peff) : (cyc + 1);
              m_wait = 0;
            end
          end else if (m_tmo != 0 && cyc == m_f + m_tmo) begin
            e_err = 1; e_busy = 0; m_mode = 2;
          end
        end else if (cyc == m_next) begin
          e_fire = 1; m_shots++; m_f = cyc; m_wait = 1;
        end
      end
      e_shot = m_shots;
    end
  end

  // Per-cycle compare, event logging and end-flag responder.
  initial forever begin
    logic [5:0] act, exp;
    int d;
    @(negedge clk);
    act = {fire, busy, cfg_lock, done, start_rej, err_timeout};
    exp = {e_fire, e_busy, e_busy, e_done, e_rej, e_err};
    n_total++;
    if (act === exp && shot_cnt === REP_W'(e_shot)) n_pass++;
    else $display("FAIL cycle_compare edge %0d: fire/busy/lock/done/rej/err got %b shot %0d, want %b shot %0d",
                  cyc, act, shot_cnt, exp, e_shot);
    if (fire) fire_log.push_back(cyc);
    if (done) done_log.push_back(cyc);
    if (start_rej) rej_log.push_back(cyc);
    if (err_timeout && !err_prev) err_log.push_back(cyc);
    err_prev = err_timeout;
    if (fire) begin
      if (rnd_end) d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20));
      else d = end_dly;
      if (d > 0) end_at = cyc + d;
    end
    if (cyc == end_at - 1) end_flg = 1'b1;
    else end_flg = 1'b0;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  function automatic longint qget(input longint q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    #1;
    fire_log.delete(); done_log.delete(); rej_log.delete(); err_log.delete();
  endtask

  task automatic pulse_start(input bit use_btn, output longint n_edge);
    @(negedge clk);
    if (use_btn) btn_start = 1'b1;
    else pc_start = 1'b1;
    n_edge = cyc + 1;
    @(negedge clk);
    btn_start = 1'b0;
    pc_start = 1'b0;
  endtask

  initial begin
    longint n0, n1, n2;
    tick(4);
    rst_n = 1'b1;
    tick(10);
    #1;
    check("reset_held_btn_no_fire", fire_log.size(), 0);
    check("reset_held_btn_busy", busy, 0);
    check("reset_shot_cnt", shot_cnt, 0);
    btn_start = 1'b0;
    tick(2);

    // Basic run.
    cfg_repeat = 8'd3; cfg_period = 24'd100; cfg_timeout = 24'd0; end_dly = 20;
    clear_logs();
    pulse_start(1'b0, n0);
    tick(260);
    #1;
    check("basic_fire_count", fire_log.size(), 3);
    check("basic_fire0", qget(fire_log, 0), n0 + 3);
    check("basic_fire1", qget(fire_log, 1), n0 + 103);
    check("basic_fire2", qget(fire_log, 2), n0 + 203);
    check("basic_done", qget(done_log, 0), n0 + 223);
    check("basic_shot_cnt", shot_cnt, 3);
    check("basic_lock_released", cfg_lock, 0);

    // Chain slower than period.
    cfg_period = 24'd10; end_dly = 50;
    clear_logs();
    pulse_start(1'b1, n0);
    tick(200);
    #1;
    check("slow_fire_count", fire_log.size(), 3);
    check("slow_spacing1", qget(fire_log, 1) - qget(fire_log, 0), 51);
    check("slow_spacing2", qget(fire_log, 2) - qget(fire_log, 1), 51);

    // Timeout.
    cfg_repeat = 8'd2; cfg_timeout = 24'd30; end_dly = 0;
    clear_logs();
    pulse_start(1'b0, n0);
    tick(60);
    #1;
    check("tmo_err_edge", qget(err_log, 0), n0 + 33);
    check("tmo_busy", busy, 0);
    check("tmo_lock", cfg_lock, 0);
    pulse_start(1'b1, n1);
    tick(10);
    #1;
    check("tmo_start_ignored", fire_log.size(), 1);
    check("tmo_no_rej", rej_log.size(), 0);
    check("tmo_err_held", err_timeout, 1);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    tick(2);
    check("tmo_abort_clears", err_timeout, 0);
    cfg_timeout = 24'd0;

    // Rejection.
    clear_logs();
    cfg_valid = 1'b0; cfg_repeat = 8'd3;
    pulse_start(1'b0, n1);
    tick(3);
    cfg_valid = 1'b1; cfg_repeat = 8'd0;
    pulse_start(1'b0, n2);
    tick(10);
    #1;
    check("rej_count", rej_log.size(), 2);
    check("rej_first", qget(rej_log, 0), n1);
    check("rej_second", qget(rej_log, 1), n2);
    check("rej_no_fire", fire_log.size(), 0);

    // Abort in the gap after two of five shots.
    cfg_repeat = 8'd5; cfg_period = 24'd100; end_dly = 20;
    clear_logs();
    pulse_start(1'b0, n0);
    tick(149);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(200);
    #1;
    check("abort_fire_count", fire_log.size(), 2);
    check("abort_shot_cnt", shot_cnt, 2);
    check("abort_no_done", done_log.size(), 0);
    check("abort_busy", busy, 0);

    // Abort together with a start edge in idle.
    clear_logs();
    @(negedge clk); abort = 1'b1; btn_start = 1'b1;
    @(negedge clk); abort = 1'b0; btn_start = 1'b0;
    tick(10);
    #1;
    check("abort_start_no_rej", rej_log.size(), 0);
    check("abort_start_no_run", fire_log.size(), 0);

    // Config changes during a run have no effect.
    cfg_repeat = 8'd3; cfg_period = 24'd100; end_dly = 20;
    clear_logs();
    pulse_start(1'b1, n0);
    tick(10);
    cfg_period = 24'd10;
    tick(250);
    #1;
    check("iso_spacing1", qget(fire_log, 1) - qget(fire_log, 0), 100);
    check("iso_spacing2", qget(fire_log, 2) - qget(fire_log, 1), 100);

    // Randomized phase, checked by the per-cycle model compare.
    rnd_end = 1'b1;
    for (int it = 0; it < 40; it++) begin
      cfg_valid   = ($urandom_range(0, 9) != 0);
      cfg_repeat  = REP_W'($urandom_range(0, 4));
      cfg_period  = CNT_W'($urandom_range(0, 12));
      cfg_timeout = ($urandom_range(0, 2) == 0) ? CNT_W'(0) : CNT_W'($urandom_range(1, 25));
      for (int c = 0; c < 250; c++) begin
        @(negedge clk);
        btn_start = ($urandom_range(0, 59) == 0);
        pc_start  = ($urandom_range(0, 59) == 0);
        abort     = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 19) == 0) cfg_repeat = REP_W'($urandom_range(0, 4));
        if ($urandom_range(0, 19) == 0) cfg_period = CNT_W'($urandom_range(0, 12));
        if ($urandom_range(0, 29) == 0) cfg_valid = ~cfg_valid;
      end
      @(negedge clk); btn_start = 1'b0; pc_start = 1'b0; abort = 1'b1;
      @(negedge clk); abort = 1'b0;
    end
    tick(5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
